// File: rtl/bus_timing_pkg.sv
// Shared frame timing for the bus sequencer: default slot window tables and
// the elaboration-time helpers for position width and window legality.
package bus_timing_pkg;

  localparam int DEF_NUM_SLOTS = 2;

  // Index 0 is slot 0: {SEL, SUB, STB} bounds per slot.
  localparam logic [DEF_NUM_SLOTS-1:0][7:0] DEF_SEL_START = {8'd12, 8'd0};
  localparam logic [DEF_NUM_SLOTS-1:0][7:0] DEF_SEL_END   = {8'd15, 8'd2};
  localparam logic [DEF_NUM_SLOTS-1:0][7:0] DEF_SUB_START = {8'd13, 8'd0};
  localparam logic [DEF_NUM_SLOTS-1:0][7:0] DEF_SUB_END   = {8'd15, 8'd2};
  localparam logic [DEF_NUM_SLOTS-1:0][7:0] DEF_STB_START = {8'd14, 8'd1};
  localparam logic [DEF_NUM_SLOTS-1:0][7:0] DEF_STB_END   = {8'd14, 8'd1};

  function automatic int pos_width(input int period);
    return (period <= 2) ? 1 : $clog2(period);
  endfunction

  // Sub-select and strobe must nest inside the select window, which must fit the frame.
  function automatic bit window_ok(input int period,
                                   input int sel_s, input int sel_e,
                                   input int sub_s, input int sub_e,
                                   input int stb_s, input int stb_e);
    return (sel_s <= sub_s) && (sub_s <= sub_e) && (sub_e <= sel_e) &&
           (sel_s <= stb_s) && (stb_s <= stb_e) && (stb_e <= sel_e) &&
           (sel_e < period);
  endfunction

  function automatic bit windows_overlap(input int a_s, input int a_e,
                                         input int b_s, input int b_e);
    return (a_s <= b_e) && (b_s <= a_e);
  endfunction

  function automatic logic in_window(input logic [7:0] pos,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// Per-slot request/select bundle between the requesters and the slot decoders.
interface bus_sequencer_if #(
  parameter int NUM_SLOTS = 2
);
  logic [NUM_SLOTS-1:0] req;
  logic [NUM_SLOTS-1:0] select;
  logic [NUM_SLOTS-1:0] sub_select;
  logic [NUM_SLOTS-1:0] strobe;
  logic [NUM_SLOTS-1:0] ack;

  modport master (output req, input select, sub_select, strobe, ack);
  modport slave  (input req, output select, sub_select, strobe, ack);
endinterface

// File: rtl/bus_slot.sv
// One bus-master slot: samples its request one cycle ahead of the select window,
// decodes select/sub-select/strobe from the next frame position and acks after.
module bus_slot
  import bus_timing_pkg::*;
#(
  parameter int         PERIOD    = 16,
  parameter int         SLOT      = 0,
  parameter logic [7:0] SEL_START = 8'd0,
  parameter logic [7:0] SEL_END   = 8'd2,
  parameter logic [7:0] SUB_START = 8'd0,
  parameter logic [7:0] SUB_END   = 8'd2,
  parameter logic [7:0] STB_START = 8'd1,
  parameter logic [7:0] STB_END   = 8'd1,
  parameter bit         ON_DEMAND = 1'b0
) (
  input  logic           clk16,
  input  logic           reset_n,
  input  logic [7:0]     pos_next_i,
  bus_sequencer_if.slave bus
);

  localparam logic [7:0] ACK_POS = 8'((int'(SEL_END) + 1) % PERIOD);

  if (!window_ok(PERIOD, int'(SEL_START), int'(SEL_END), int'(SUB_START),
                 int'(SUB_END), int'(STB_START), int'(STB_END))) begin : g_bad_window
    $error("bus_slot %0d: sub/strobe windows must nest in select window inside the frame", SLOT);
  end

  logic grant_q, grant_d;
  logic select_q, select_d;
  logic sub_select_q, sub_select_d;
  logic strobe_q, strobe_d;
  logic ack_q, ack_d;

  // grant_q holds the decision for the current (or most recent) window until the
  // next window start; the ack therefore reads the old value on its edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_d = grant_q;
    if (pos_next_i == SEL_START) begin
      grant_d = ON_DEMAND ? bus.req[SLOT] : 1'b1;
    end
    select_d     = grant_d && in_window(pos_next_i, SEL_START, SEL_END);
    sub_select_d = grant_d && in_window(pos_next_i, SUB_START, SUB_END);
    strobe_d     = grant_d && in_window(pos_next_i, STB_START, STB_END);
    ack_d        = grant_q && (pos_next_i == ACK_POS);
  end

  // NOTE: sequential state uses non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= 1'b0;
      select_q     <= 1'b0;
      sub_select_q <= 1'b0;
      strobe_q     <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      select_q     <= select_d;
      sub_select_q <= sub_select_d;
      strobe_q     <= strobe_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.select[SLOT]     = select_q;
  assign bus.sub_select[SLOT] = sub_select_q;
  assign bus.strobe[SLOT]     = strobe_q;
  assign bus.ack[SLOT]        = ack_q;

endmodule

// File: rtl/bus_sequencer.sv
// Frame position counter driving NUM_SLOTS slot decoders; all slot outputs are
// registered against the next position so they line up with pos_o.
module bus_sequencer
  import bus_timing_pkg::*;
#(
  parameter int                        PERIOD    = 16,
  parameter int                        NUM_SLOTS = DEF_NUM_SLOTS,
  parameter logic [NUM_SLOTS-1:0][7:0] SEL_START = DEF_SEL_START,
  parameter logic [NUM_SLOTS-1:0][7:0] SEL_END   = DEF_SEL_END,
  parameter logic [NUM_SLOTS-1:0][7:0] SUB_START = DEF_SUB_START,
  parameter logic [NUM_SLOTS-1:0][7:0] SUB_END   = DEF_SUB_END,
  parameter logic [NUM_SLOTS-1:0][7:0] STB_START = DEF_STB_START,
  parameter logic [NUM_SLOTS-1:0][7:0] STB_END   = DEF_STB_END,
  parameter logic [NUM_SLOTS-1:0]      ON_DEMAND = '0
) (
  input  logic                          clk16,
  input  logic                          reset_n,
  input  logic [NUM_SLOTS-1:0]          req_i,
  output logic [NUM_SLOTS-1:0]          select_o,
  output logic [NUM_SLOTS-1:0]          sub_select_o,
  output logic [NUM_SLOTS-1:0]          strobe_o,
  output logic [NUM_SLOTS-1:0]          ack_o,
  output logic [pos_width(PERIOD)-1:0]  pos_o,
  output logic                          frame_start_o,
  output logic                          clk8
);

  localparam int PW = pos_width(PERIOD);

  if ((PERIOD % 2) != 0 || PERIOD < 4 || PERIOD > 256) begin : g_bad_period
    $error("bus_sequencer: PERIOD %0d must be even and within 4..256", PERIOD);
  end

  if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_slots
    $error("bus_sequencer: NUM_SLOTS %0d must be within 1..8", NUM_SLOTS);
  end

  // Two masters may never own the bus in the same cycle.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_overlap_i
    for (genvar j = i + 1; j < NUM_SLOTS; j++) begin : g_overlap_j
      if (windows_overlap(int'(SEL_START[i]), int'(SEL_END[i]),
                          int'(SEL_START[j]), int'(SEL_END[j]))) begin : g_bad_overlap
        $error("bus_sequencer: select windows of slots %0d and %0d overlap", i, j);
      end
    end
  end

  logic [PW-1:0] pos_q, pos_d;
  logic [7:0]    pos_next;

  always_comb begin
    pos_d = (pos_q == PW'(PERIOD - 1)) ? '0 : pos_q + 1'b1;
  end

  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_next = 8'(pos_d);

  bus_sequencer_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();

  assign bus.req = req_i;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    bus_slot #(
      .PERIOD    (PERIOD),
      .SLOT      (s),
      .SEL_START (SEL_START[s]),
      .SEL_END   (SEL_END[s]),
      .SUB_START (SUB_START[s]),
      .SUB_END   (SUB_END[s]),
      .STB_START (STB_START[s]),
      .STB_END   (STB_END[s]),
      .ON_DEMAND (ON_DEMAND[s])
    ) u_slot (
      .clk16      (clk16),
      .reset_n    (reset_n),
      .pos_next_i (pos_next),
      .bus        (bus)
    );
  end

  assign select_o      = bus.select;
  assign sub_select_o  = bus.sub_select;
  assign strobe_o      = bus.strobe;
  assign ack_o         = bus.ack;
  assign pos_o         = pos_q;
  assign frame_start_o = (pos_q == '0);
  assign clk8          = pos_q[0];

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: two configurations driven together, expected
// outputs from an absolute-time window model, compared by an independent monitor.
module tb_bus_sequencer;

  typedef struct packed {
    logic [7:0] pos;
    logic       fs;
    logic       c8;
    logic [7:0] sel;
    logic [7:0] sub;
    logic [7:0] stb;
    logic [7:0] ack;
  } obs_t;

  typedef struct {
    int   d;
    int   cyc;
    obs_t v;
  } exp_t;

  logic clk16 = 1'b0;
  logic reset_n;
  always #5 clk16 = ~clk16;

  bus_sequencer_if #(.NUM_SLOTS(2)) a_bus ();
  bus_sequencer_if #(.NUM_SLOTS(3)) b_bus ();
  logic [3:0] a_pos, b_pos;
  logic       a_fs, a_c8, b_fs, b_c8;

  bus_sequencer #(.ON_DEMAND(2'b10)) dut_a (
    .clk16(clk16), .reset_n(reset_n), .req_i(a_bus.req),
    .select_o(a_bus.select), .sub_select_o(a_bus.sub_select),
    .strobe_o(a_bus.strobe), .ack_o(a_bus.ack),
    .pos_o(a_pos), .frame_start_o(a_fs), .clk8(a_c8)
  );

  bus_sequencer #(
    .PERIOD(10), .NUM_SLOTS(3),
    .SEL_START({8'd8, 8'd5, 8'd1}), .SEL_END({8'd9, 8'd6, 8'd3}),
    .SUB_START({8'd8, 8'd5, 8'd2}), .SUB_END({8'd9, 8'd5, 8'd3}),
    .STB_START({8'd9, 8'd6, 8'd2}), .STB_END({8'd9, 8'd6, 8'd2}),
    .ON_DEMAND(3'b101)
  ) dut_b (
    .clk16(clk16), .reset_n(reset_n), .req_i(b_bus.req),
    .select_o(b_bus.select), .sub_select_o(b_bus.sub_select),
    .strobe_o(b_bus.strobe), .ack_o(b_bus.ack),
    .pos_o(b_pos), .frame_start_o(b_fs), .clk8(b_c8)
  );

  // Reference model: each granted window is remembered by the absolute cycle it
  // starts in; outputs follow from the offset of the current cycle into it.
  int per[2], nsl[2];
  int ss[2][8], se[2][8], bs[2][8], be[2][8], ts[2][8], te[2][8];
  bit od[2][8];
  int cyc[2];
  int win[2][8][2];

  logic [1:0] a_req;
  logic [2:0] b_req;
  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  event       sample_ev;

  task automatic set_slot(input int d, input int s, input int s_s, input int s_e,
                          input int u_s, input int u_e, input int t_s, input int t_e, input bit o);
    ss[d][s] = s_s; se[d][s] = s_e; bs[d][s] = u_s; be[d][s] = u_e;
    ts[d][s] = t_s; te[d][s] = t_e; od[d][s] = o;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0;
      for (int s = 0; s < 8; s++) begin
        win[d][s][0] = -1000;
        win[d][s][1] = -1000;
      end
    end
  endtask

  // One clock edge: a slot's window begins on the edge into its start position,
  // decided by the request level held during the cycle before.
  task automatic model_edge(input int d, input logic [7:0] r);
    int p;
    cyc[d]++;
    p = cyc[d] % per[d];
    for (int s = 0; s < nsl[d]; s++) begin
      if (p == ss[d][s] && (!od[d][s] || r[s])) begin
        win[d][s][1] = win[d][s][0];
        win[d][s][0] = cyc[d];
      end
    end
  endtask

  function automatic obs_t model_out(input int d);
    obs_t o;
    int   p, off, len;
    o = '0;
    p = cyc[d] % per[d];
    o.pos = 8'(p);
    o.fs  = (p == 0);
    o.c8  = ((p % 2) == 1);
    for (int s = 0; s < nsl[d]; s++) begin
      len = se[d][s] - ss[d][s] + 1;
      for (int w = 0; w < 2; w++) begin
        off = cyc[d] - win[d][s][w];
        if (off >= 0 && off < len) o.sel[s] = 1'b1;
        if (off >= bs[d][s] - ss[d][s] && off <= be[d][s] - ss[d][s]) o.sub[s] = 1'b1;
        if (off >= ts[d][s] - ss[d][s] && off <= te[d][s] - ss[d][s]) o.stb[s] = 1'b1;
        if (off == len) o.ack[s] = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic obs_t observe(input int d);
    obs_t o;
    if (d == 0) begin
      o = '{pos: 8'(a_pos), fs: a_fs, c8: a_c8, sel: 8'(a_bus.select),
            sub: 8'(a_bus.sub_select), stb: 8'(a_bus.strobe), ack: 8'(a_bus.ack)};
    end else begin
      o = '{pos: 8'(b_pos), fs: b_fs, c8: b_c8, sel: 8'(b_bus.select),
            sub: 8'(b_bus.sub_select), stb: 8'(b_bus.strobe), ack: 8'(b_bus.ack)};
    end
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got pos=%0d fs=%b c8=%b sel=%b sub=%b stb=%b ack=%b, expected pos=%0d fs=%b c8=%b sel=%b sub=%b stb=%b ack=%b",
               name, act.pos, act.fs, act.c8, act.sel, act.sub, act.stb, act.ack,
               exp.pos, exp.fs, exp.c8, exp.sel, exp.sub, exp.stb, exp.ack);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e.d   = d;
      e.cyc = cyc[d];
      e.v   = model_out(d);
      exp_q.push_back(e);
    end
  endtask

  // Drive inputs mid-cycle, advance the model over the coming edge, queue the result.
  task automatic tick(input bit release_rst);
    @(negedge clk16);
    if (release_rst) reset_n = 1'b1;
    if ($urandom_range(3) == 0) b_req = 3'($urandom);
    a_bus.req = a_req;
    b_bus.req = b_req;
    if (reset_n) begin
      model_edge(0, 8'(a_req));
      model_edge(1, 8'(b_req));
    end
    push_exp();
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk16);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    -> sample_ev;
    repeat (hold) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic run_to(input int p);
    int guard;
    guard = 0;
    while ((cyc[0] % per[0]) != p && guard < 64) begin
      tick(1'b0);
      guard++;
    end
  endtask

  always @(posedge clk16) begin
    #2;
    -> sample_ev;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("dut_%s cycle %0d", (e.d == 0) ? "a" : "b", e.cyc), observe(e.d), e.v);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    per[0] = 16; nsl[0] = 2;
    set_slot(0, 0, 0, 2, 0, 2, 1, 1, 1'b0);
    set_slot(0, 1, 12, 15, 13, 15, 14, 14, 1'b1);
    per[1] = 10; nsl[1] = 3;
    set_slot(1, 0, 1, 3, 2, 3, 2, 2, 1'b1);
    set_slot(1, 1, 5, 6, 5, 5, 6, 6, 1'b0);
    set_slot(1, 2, 8, 9, 8, 9, 9, 9, 1'b1);

    reset_n = 1'b0;
    a_req = '0;
    b_req = '0;
    a_bus.req = '0;
    b_bus.req = '0;
    model_reset();
    repeat (3) tick(1'b0);
    tick(1'b1);

    // Two frames with no requests: only the always-on slots act.
    repeat (32) tick(1'b0);

    // Request raised at pos 5 and held through the ack, then dropped.
    run_to(5);  a_req = 2'b10;
    run_to(0);  a_req = 2'b00;
    run_to(1);  run_to(0);

    // Request raised at pos 12 misses this frame, granted in the next.
    run_to(12); a_req = 2'b10;
    run_to(0);  run_to(1);  run_to(0);
    a_req = 2'b00;
    run_to(1);

    // Request dropped mid-window: window still completes and acks.
    a_req = 2'b10;
    run_to(13); a_req = 2'b00;
    run_to(1);  run_to(0);

    // Reset in the middle of slot 1's window.
    a_req = 2'b10;
    run_to(14);
    pulse_reset(2);
    repeat (20) tick(1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) a_req = 2'($urandom);
      if ($urandom_range(199) == 0) pulse_reset(int'($urandom_range(1, 3)));
      else tick(1'b0);
    end
    repeat (32) tick(1'b0);

    @(posedge clk16);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter PERIOD, default 16, meaning clk16 cycles per bus frame (even, 4..256).
REQ-002 SHALL have parameter NUM_SLOTS, default 2, meaning number of bus-master slots (1..8).
REQ-003 SHALL have parameters SEL_START, SEL_END, SUB_START, SUB_END, STB_START, STB_END, each a packed array of NUM_SLOTS 8-bit frame positions, meaning per-slot window bounds; defaults are slot0 {0,2,0,2,1,1}, slot1 {12,15,13,15,14,14}.
REQ-004 SHALL have parameter ON_DEMAND, NUM_SLOTS bits, default all 0, meaning a 1 makes that slot request-gated and a 0 makes it always-on.
REQ-005 SHALL have port clk16, input, 1 bit: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_i, input, NUM_SLOTS bits: per-slot access request, level-held until ack.
REQ-008 SHALL have port select_o, output, NUM_SLOTS bits: per-slot bus select.
REQ-009 SHALL have port sub_select_o, output, NUM_SLOTS bits: per-slot secondary (I/O) select.
REQ-010 SHALL have port strobe_o, output, NUM_SLOTS bits: per-slot data strobe.
REQ-011 SHALL have port ack_o, output, NUM_SLOTS bits: per-slot one-cycle completion pulse.
REQ-012 SHALL have port pos_o, output, clog2(PERIOD) bits: current frame position.
REQ-013 SHALL have port frame_start_o, output, 1 bit: high while pos_o == 0.
REQ-014 SHALL have port clk8, output, 1 bit: pos_o[0].

Function
REQ-015 SHALL increment pos_o by 1 each clk16 edge, wrapping from PERIOD-1 to 0.
REQ-016 SHALL register all select, sub-select, strobe and ack outputs so that each is glitch-free and aligned with pos_o; the decode uses the next position.
REQ-017 SHALL drive select_o[i] high exactly in cycles where pos_o is in [SEL_START[i], SEL_END[i]] and slot i is active for the current frame.
REQ-018 SHALL drive sub_select_o[i] and strobe_o[i] under the same rule, using their own windows.
REQ-019 SHALL treat an always-on slot as active every frame and ignore its req_i.
REQ-020 SHALL sample req_i[i] of an on-demand slot in the cycle where pos_o == (SEL_START[i]-1) mod PERIOD; if it is high, the slot is active for that window, otherwise all its outputs stay low for that frame.
REQ-021 SHALL keep an active window complete even if req_i drops mid-window, and SHALL NOT start a window on a req_i rise after the sample cycle.
REQ-022 SHALL pulse ack_o[i] for exactly one cycle, at pos_o == (SEL_END[i]+1) mod PERIOD, after each active window, including a window ending at PERIOD-1, whose ack appears at pos 0.
REQ-023 SHALL allow an on-demand requester holding req_i through ack to be re-granted in the next frame.
REQ-024 SHALL reject at elaboration, via $error, any slot violating SEL_START <= SUB_START <= SUB_END <= SEL_END, SEL_START <= STB_START <= STB_END <= SEL_END, or SEL_END < PERIOD.
REQ-025 SHALL reject at elaboration any two slots with overlapping select windows, and any odd PERIOD.

Reset
REQ-026 SHALL, while reset_n is low and regardless of clock, hold pos_o = 0 and all slot outputs = 0, with all slots inactive.
REQ-027 SHALL, on the first edge after release, move to pos_o = 1, with outputs reflecting pos 1; any window covering pos 0 is skipped in that first frame.
REQ-028 SHALL, on reset asserted mid-window, drop select, sub-select and strobe immediately and issue no ack for the aborted window.

Structure
REQ-029 SHALL place the default window tables, the position-width function and the window-check function in shared package bus_timing_pkg.
REQ-030 SHALL implement per-slot window decode, request latch and ack in sub-module bus_slot, instantiated NUM_SLOTS times; the top holds only the position counter.

Verification
REQ-031 Defaults, req_i = 0, 2 frames: select_o[0] high at pos 0-2, strobe_o[0] at pos 1, select_o[1] at 12-15, sub_select_o[1] at 13-15, strobe_o[1] at 14; ack_o[1] at pos 0; clk8 toggles every edge.
REQ-032 ON_DEMAND = 2'b10, req_i[1] raised at pos 5 and held: slot 1 windows at 12-15, ack_o[1] at pos 0; req_i[1] dropped after ack: no slot 1 activity in the next frame.
REQ-033 ON_DEMAND = 2'b10, req_i[1] raised at pos 12: no window this frame; grant in the following frame.
REQ-034 ON_DEMAND = 2'b10, req_i[1] dropped at pos 13 of an active window: window completes to 15, ack_o[1] pulses at 0.
REQ-035 reset_n low at pos 14: all outputs 0 immediately, no ack; after release, pos sequence is 1,2,… and slot 0 first asserts at the next pos 0.
REQ-036 PERIOD = 10, NUM_SLOTS = 3, non-overlapping windows: wrap 9->0, frame_start_o once per 10 cycles; overlapping windows fail elaboration.
